// File: rtl/cordic_pipelined_if.sv
// Handshake and data bundle for the pipelined CORDIC engine.
// The engine itself uses the slave view; producers/consumers use the master view.
interface cordic_pipelined_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic [WIDTH-1:0] in_z;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_x;
  logic [WIDTH-1:0] out_y;
  logic [WIDTH-1:0] out_z;
  logic [TAG_W-1:0] out_tag;
  logic             out_mode;

  modport slave (
    input  in_valid, in_mode, in_x, in_y, in_z, in_tag, out_ready,
    output in_ready, out_valid, out_x, out_y, out_z, out_tag, out_mode
  );

  modport master (
    output in_valid, in_mode, in_x, in_y, in_z, in_tag, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_z, out_tag, out_mode
  );
endinterface

// File: rtl/cordic_pipelined.sv
// Fully pipelined rotation/vectoring CORDIC: quadrant pre-rotation stage,
// ITER micro-rotation stages and a saturating output register, one result per clock.
module cordic_pipelined #(
  parameter int WIDTH = 32,
  parameter int ITER  = 16,
  parameter int TAG_W = 4
) (
  input logic               clk,
  input logic               rst,
  cordic_pipelined_if.slave bus
);

  localparam int XW = WIDTH + 2;

  // round(atan(2^-i)/pi * 2^31), rescaled to WIDTH with round-half-up
  function automatic logic signed [WIDTH-1:0] atan_coef(input int unsigned i);
    logic [31:0]        t;
    logic signed [32:0] c;
    case (i)
      0:  t = 32'h20000000;  1:  t = 32'h12E4051E;  2:  t = 32'h09FB385B;
      3:  t = 32'h051111D4;  4:  t = 32'h028B0D43;  5:  t = 32'h0145D7E1;
      6:  t = 32'h00A2F61E;  7:  t = 32'h00517C55;  8:  t = 32'h0028BE53;
      9:  t = 32'h00145F2F;  10: t = 32'h000A2F98;  11: t = 32'h000517CC;
      12: t = 32'h00028BE6;  13: t = 32'h000145F3;  14: t = 32'h0000A2FA;
      15: t = 32'h0000517D;  16: t = 32'h000028BE;  17: t = 32'h0000145F;
      18: t = 32'h00000A30;  19: t = 32'h00000518;  20: t = 32'h0000028C;
      21: t = 32'h00000146;  22: t = 32'h000000A3;  23: t = 32'h00000051;
      24: t = 32'h00000029;  25: t = 32'h00000014;  26: t = 32'h0000000A;
      27: t = 32'h00000005;  28: t = 32'h00000003;  29: t = 32'h00000001;
      30: t = 32'h00000001;  default: t = 32'h00000000;
    endcase
    c = $signed({1'b0, t});
    return WIDTH'((c + ((33'sd1 <<< (32 - WIDTH)) >>> 1)) >>> (32 - WIDTH));
  endfunction

  function automatic logic [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
    if (v[XW-1:WIDTH-1] == '0 || v[XW-1:WIDTH-1] == '1)
      return v[WIDTH-1:0];
    return v[XW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  logic signed [XW-1:0]    xs [0:ITER];
  logic signed [XW-1:0]    ys [0:ITER];
  logic signed [WIDTH-1:0] zs [0:ITER];
  logic                    vs [0:ITER];
  logic                    ms [0:ITER];
  logic [TAG_W-1:0]        ts [0:ITER];
  logic                    dir [0:ITER-1];

  logic                    advance;
  logic signed [XW-1:0]    x_in;
  logic signed [XW-1:0]    y_in;
  logic                    flip;

  // Global stall: nothing moves while a finished result is waiting to be taken.
  assign advance      = !(bus.out_valid && !bus.out_ready);
  assign bus.in_ready = advance;

  assign x_in = {{2{bus.in_x[WIDTH-1]}}, bus.in_x};
  assign y_in = {{2{bus.in_y[WIDTH-1]}}, bus.in_y};
  assign flip = bus.in_mode ? bus.in_x[WIDTH-1]
                            : (bus.in_z[WIDTH-1] ^ bus.in_z[WIDTH-2]);

  // dir = 1 selects d = +1 (counter-clockwise micro-rotation)
  always_comb begin
    for (int unsigned i = 0; i < ITER; i++)
      dir[i] = ms[i] ? ys[i][XW-1] : !zs[i][WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i <= ITER; i++) vs[i] <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_x     <= '0;
      bus.out_y     <= '0;
      bus.out_z     <= '0;
      bus.out_tag   <= '0;
      bus.out_mode  <= 1'b0;
    end else if (advance) begin
      vs[0] <= bus.in_valid;
      ms[0] <= bus.in_mode;
      ts[0] <= bus.in_tag;
      xs[0] <= flip ? -x_in : x_in;
      ys[0] <= flip ? -y_in : y_in;
      zs[0] <= {bus.in_z[WIDTH-1] ^ flip, bus.in_z[WIDTH-2:0]};
      for (int unsigned i = 0; i < ITER; i++) begin
        vs[i+1] <= vs[i];
        ms[i+1] <= ms[i];
        ts[i+1] <= ts[i];
        if (dir[i]) begin
          xs[i+1] <= xs[i] - (ys[i] >>> i);
          ys[i+1] <= ys[i] + (xs[i] >>> i);
          zs[i+1] <= zs[i] - atan_coef(i);
        end else begin
          xs[i+1] <= xs[i] + (ys[i] >>> i);
          ys[i+1] <= ys[i] - (xs[i] >>> i);
          zs[i+1] <= zs[i] + atan_coef(i);
        end
      end
      bus.out_valid <= vs[ITER];
      bus.out_x     <= sat(xs[ITER]);
      bus.out_y     <= sat(ys[ITER]);
      bus.out_z     <= zs[ITER];
      bus.out_tag   <= ts[ITER];
      bus.out_mode  <= ms[ITER];
    end
  end

endmodule

// File: tb/tb_cordic_pipelined.sv
// Self-checking bench for cordic_pipelined: directed and random transactions
// scored against a floating-point rotation/vectoring model with gain An.
module tb_cordic_pipelined;
  localparam int W  = 32;
  localparam int N  = 16;
  localparam int TW = 4;
  localparam longint TOL = longint'(1) << (W - N);
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cordic_pipelined_if #(.WIDTH(W), .TAG_W(TW)) bus ();
  cordic_pipelined #(.WIDTH(W), .ITER(N), .TAG_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [TW-1:0] tag;
    logic          mode;
    longint        x, y, z;
    bit            xsat, ysat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input longint got, input longint exp, input longint tol);
    checks++;
    if (got - exp > tol || exp - got > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at %0t", tag, got, exp, tol, $time);
    end
  endtask

  function automatic longint wrapdiff(input longint a, input longint b);
    longint m = longint'(1) << W;
    longint d = (a - b) % m;
    if (d < 0) d += m;
    if (d >= m / 2) d -= m;
    return d;
  endfunction

  function automatic longint clampr(input real r, output bit s);
    real hi = real'((longint'(1) << (W - 1)) - 1);
    real lo = -real'(longint'(1) << (W - 1));
    s = 1'b1;
    if (r > hi) return longint'(hi);
    if (r < lo) return longint'(lo);
    s = 1'b0;
    return longint'(r);
  endfunction

  function automatic exp_t model(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [W-1:0] z, input logic [TW-1:0] tag);
    exp_t e;
    real an = 1.0, p = 1.0, rx, ry, rz, th;
    real fx = real'($signed(x));
    real fy = real'($signed(y));
    real fz = real'($signed(z));
    real half = real'(longint'(1) << (W - 1));
    for (int i = 0; i < N; i++) begin
      an = an * $sqrt(1.0 + p);
      p  = p / 4.0;
    end
    if (!m) begin
      th = fz * PI / half;
      rx = an * (fx * $cos(th) - fy * $sin(th));
      ry = an * (fx * $sin(th) + fy * $cos(th));
      rz = 0.0;
    end else begin
      rx = an * $sqrt(fx * fx + fy * fy);
      ry = 0.0;
      rz = fz + $atan2(fy, fx) * half / PI;
    end
    e.tag  = tag;
    e.mode = m;
    e.x    = clampr(rx, e.xsat);
    e.y    = clampr(ry, e.ysat);
    e.z    = longint'(rz);
    return e;
  endfunction

  // Scoreboard: outputs compared when consumed, inputs modelled when accepted.
  logic          prev_stall = 1'b0;
  logic [W-1:0]  px, py, pz;
  logic [TW-1:0] pt;
  logic          pm;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      prev_stall <= 1'b0;
    end else begin
      check("in_ready", longint'(bus.in_ready), longint'(!(bus.out_valid && !bus.out_ready)), 0);
      if (prev_stall) begin
        check("hold_valid", longint'(bus.out_valid), 1, 0);
        check("hold_x", longint'(bus.out_x), longint'(px), 0);
        check("hold_y", longint'(bus.out_y), longint'(py), 0);
        check("hold_z", longint'(bus.out_z), longint'(pz), 0);
        check("hold_tag", longint'(bus.out_tag), longint'(pt), 0);
        check("hold_mode", longint'(bus.out_mode), longint'(pm), 0);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", longint'(bus.out_valid), 0, 0);
        end else begin
          e = sb.pop_front();
          check("out_tag", longint'(bus.out_tag), longint'(e.tag), 0);
          check("out_mode", longint'(bus.out_mode), longint'(e.mode), 0);
          check("out_x", longint'($signed(bus.out_x)), e.x, e.xsat ? 0 : TOL);
          check("out_y", longint'($signed(bus.out_y)), e.y, e.ysat ? 0 : TOL);
          check("out_z", wrapdiff(longint'(bus.out_z), e.z), 0, TOL);
        end
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back(model(bus.in_mode, bus.in_x, bus.in_y, bus.in_z, bus.in_tag));
      prev_stall <= bus.out_valid && !bus.out_ready;
      px <= bus.out_x;
      py <= bus.out_y;
      pz <= bus.out_z;
      pt <= bus.out_tag;
      pm <= bus.out_mode;
    end
  end

  task automatic set_in(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] z, input logic [TW-1:0] tag);
    bus.in_mode = m;
    bus.in_x    = x;
    bus.in_y    = y;
    bus.in_z    = z;
    bus.in_tag  = tag;
  endtask

  // Offers one input with out_ready=1 and measures edges until out_valid.
  task automatic send_one(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] z, input logic [TW-1:0] tag);
    int n = 0;
    @(posedge clk); #1;
    set_in(m, x, y, z, tag);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, N + 1, 0);
  endtask

  task automatic gen(output logic m, output logic [W-1:0] x, output logic [W-1:0] y,
                     output logic [W-1:0] z);
    real mag = 0.25 + 0.45 * real'($urandom_range(0, 1000)) / 1000.0;
    real ang = 2.0 * PI * real'($urandom_range(0, 65535)) / 65536.0;
    real one = real'(longint'(1) << (W - 2));
    m = 1'($urandom_range(0, 1));
    x = W'(longint'(mag * $cos(ang) * one));
    y = W'(longint'(mag * $sin(ang) * one));
    z = W'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] kc;
  logic         cm;
  logic [W-1:0] cx, cy, cz;

  initial begin
    int sent, budget, seen;
    bit acc;
    kc = W'(32'sh26DD3B6A >>> (32 - W));
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_in(1'b0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", longint'(bus.out_valid), 0, 0);
    check("rst_in_ready", longint'(bus.in_ready), 1, 0);
    check("rst_out_x", longint'(bus.out_x), 0, 0);

    // Directed: sin/cos, quadrant correction, vectoring, saturation
    send_one(1'b0, kc, '0, 32'h2CAE3080, 4'd1);
    send_one(1'b0, kc, '0, 32'h60000000, 4'd2);
    send_one(1'b0, kc, '0, 32'h80000000, 4'd3);
    check("pi_x", longint'($signed(bus.out_x)), -(longint'(1) << (W - 2)), TOL);
    send_one(1'b1, '0, 32'hC0000000, '0, 4'd4);
    check("vec_z", wrapdiff(longint'(bus.out_z), 64'hC0000000), 0, TOL);
    send_one(1'b1, 32'hC0000000, '0, '0, 4'd5);
    send_one(1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, '0, 4'd6);
    check("sat_x", longint'(bus.out_x), 64'h7FFFFFFF, 0);

    // Random mixed-mode stream with 50% backpressure
    sent = 0;
    budget = 0;
    gen(cm, cx, cy, cz);
    @(posedge clk); #1;
    while ((sent < 40 || sb.size() > 0) && budget < 2000) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if (sent < 40) begin
        set_in(cm, cx, cy, cz, TW'(sent));
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      budget++;
      if (acc) begin
        sent++;
        gen(cm, cx, cy, cz);
      end
    end
    check("stream_done", longint'(sb.size()) + longint'(40 - sent), 0, 0);

    // Reset with five transactions in flight and one offered on the reset edge
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      gen(cm, cx, cy, cz);
      set_in(cm, cx, cy, cz, TW'(8 + k));
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    gen(cm, cx, cy, cz);
    set_in(cm, cx, cy, cz, 4'd15);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("mid_rst_valid", longint'(bus.out_valid), 0, 0);
    check("mid_rst_ready", longint'(bus.in_ready), 1, 0);
    check("mid_rst_x", longint'(bus.out_x), 0, 0);
    check("mid_rst_y", longint'(bus.out_y), 0, 0);
    check("mid_rst_z", longint'(bus.out_z), 0, 0);
    check("mid_rst_tag", longint'(bus.out_tag), 0, 0);
    check("mid_rst_mode", longint'(bus.out_mode), 0, 0);
    seen = 0;
    repeat (3 * N) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("flushed_quiet", seen, 0, 0);
    gen(cm, cx, cy, cz);
    send_one(cm, cx, cy, cz, 4'd7);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("sb_empty", longint'(sb.size()), 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
